// File: rtl/serie_paralelo_pkg.sv
// serie_paralelo_pkg: shared constants and state encoding for the serial-to-parallel receiver.
package sp_pkg;
    localparam int WIDTH_DEF = 8;
    localparam logic [7:0] COMMA = 8'hBC;
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;
endpackage

// File: rtl/serie_paralelo_if.sv
// serie_paralelo_if: serial input and parallel byte outputs of the receiver.
interface serie_paralelo_if #(parameter int WIDTH = 8);
    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             active;
    logic             byte_stb;
    modport master (output data_in, input data_out, valid_out, active, byte_stb);
    modport slave (input data_in, output data_out, valid_out, active, byte_stb);
endinterface

// File: rtl/serie_paralelo_comma_align.sv
// sp_comma_align: bit-sliding comma hunt, byte-alignment lock and boundary tracking.
module sp_comma_align
    import sp_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] COMMA       = sp_pkg::COMMA,
    parameter int               COMMA_COUNT = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] w,
    output logic             is_comma,
    output logic             boundary,
    output logic             active
);
    localparam int CW = $clog2(WIDTH);
    localparam int NW = $clog2(COMMA_COUNT + 1);
    state_t          state, state_nx;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]   bit_cnt, bit_cnt_nx;
    logic [NW-1:0]   comma_cnt, comma_cnt_nx;
    logic            at_end;
    assign w        = {sr[WIDTH-2:0], data_in};
    assign is_comma = w == COMMA;
    assign at_end   = bit_cnt == CW'(WIDTH - 1);
    assign active   = state == ACTIVE;
    assign boundary = active && at_end;
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
        end else begin
            state     <= state_nx;
            sr        <= w;
            bit_cnt   <= bit_cnt_nx;
            comma_cnt <= comma_cnt_nx;
        end
    end
    // HUNT slides one bit per edge; a comma there defines the new byte phase
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = at_end ? '0 : bit_cnt + CW'(1);
        comma_cnt_nx = comma_cnt;
        case (state)
            HUNT: begin
                bit_cnt_nx = '0;
                if (is_comma) begin
                    comma_cnt_nx = NW'(1);
                    state_nx     = COMMA_COUNT == 1 ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                if (at_end) begin
                    if (is_comma) begin
                        comma_cnt_nx = comma_cnt == NW'(COMMA_COUNT) ? comma_cnt : comma_cnt + NW'(1);
                        state_nx     = comma_cnt_nx == NW'(COMMA_COUNT) ? ACTIVE : SYNC;
                    end else begin
                        comma_cnt_nx = '0;
                        state_nx     = HUNT;
                    end
                end
            end
            ACTIVE: state_nx = ACTIVE;
            default: state_nx = HUNT;
        endcase
    end
endmodule

// File: rtl/serie_paralelo.sv
// serie_paralelo: serial-to-parallel receiver; registers aligned bytes, valid level and byte strobe.
module serie_paralelo
    import sp_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] COMMA       = sp_pkg::COMMA,
    parameter int               COMMA_COUNT = 4
) (
    input logic             clk_8f,
    input logic             reset,
    serie_paralelo_if.slave sp
);
    logic [WIDTH-1:0] w, data_q;
    logic             is_comma, boundary, active, valid_q, stb_q;
    sp_comma_align #(.WIDTH(WIDTH), .COMMA(COMMA), .COMMA_COUNT(COMMA_COUNT)) u_align (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .data_in  (sp.data_in),
        .w        (w),
        .is_comma (is_comma),
        .boundary (boundary),
        .active   (active)
    );
    // commas are idle: drop valid but keep the last data byte on the bus
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            stb_q <= boundary;
            if (boundary) begin
                valid_q <= !is_comma;
                data_q  <= is_comma ? data_q : w;
            end
        end
    end
    assign sp.data_out  = data_q;
    assign sp.valid_out = valid_q;
    assign sp.byte_stb  = stb_q;
    assign sp.active    = active;
endmodule

// File: tb/tb_serie_paralelo.sv
// tb_serie_paralelo: directed-vector bench for the comma-aligned serial receiver.
module tb_serie_paralelo;
    logic clk_8f = 1'b0;
    logic reset  = 1'b1;
    int   pass   = 0;
    int   total  = 0;
    always #2 clk_8f = ~clk_8f;
    serie_paralelo_if #(.WIDTH(8)) if0 ();
    serie_paralelo_if #(.WIDTH(8)) if1 ();
    serie_paralelo #(.WIDTH(8), .COMMA(8'hBC), .COMMA_COUNT(4)) dut0 (
        .clk_8f (clk_8f),
        .reset  (reset),
        .sp     (if0.slave)
    );
    serie_paralelo #(.WIDTH(8), .COMMA(8'hBC), .COMMA_COUNT(1)) dut1 (
        .clk_8f (clk_8f),
        .reset  (reset),
        .sp     (if1.slave)
    );
    task automatic send_bit(input logic b);
        if0.data_in = b;
        if1.data_in = b;
        @(posedge clk_8f);
        #1;
    endtask
    task automatic send_byte(input logic [7:0] v, output logic [7:0] stb);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            stb[i] = if0.byte_stb;
        end
    endtask
    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk_8f);
        #1;
        reset = 1'b0;
    endtask
    task automatic test_reset();
        if0.data_in = 1'b0;
        if1.data_in = 1'b0;
        @(posedge clk_8f);
        #1;
        total++; if (if0.data_out !== 8'h00) $display("FAIL reset_data got %h exp 00", if0.data_out); else pass++;
        total++; if (if0.valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", if0.valid_out); else pass++;
        total++; if (if0.active !== 1'b0) $display("FAIL reset_active got %b exp 0", if0.active); else pass++;
        total++; if (if0.byte_stb !== 1'b0) $display("FAIL reset_stb got %b exp 0", if0.byte_stb); else pass++;
        reset = 1'b0;
    endtask
    task automatic test_lock_data();
        logic [7:0] stb;
        for (int k = 0; k < 3; k++) send_byte(8'hBC, stb);
        total++; if (if0.active !== 1'b0) $display("FAIL lock_3commas_active got %b exp 0", if0.active); else pass++;
        send_byte(8'hBC, stb);
        total++; if (if0.active !== 1'b1) $display("FAIL lock_4commas_active got %b exp 1", if0.active); else pass++;
        total++; if (stb !== 8'h00) $display("FAIL lock_entry_stb got %b exp 00000000", stb); else pass++;
        total++; if (if0.valid_out !== 1'b0) $display("FAIL lock_entry_valid got %b exp 0", if0.valid_out); else pass++;
        send_byte(8'hFF, stb);
        total++; if (if0.data_out !== 8'hFF) $display("FAIL lock_data_ff got %h exp ff", if0.data_out); else pass++;
        total++; if (if0.valid_out !== 1'b1) $display("FAIL lock_valid_ff got %b exp 1", if0.valid_out); else pass++;
        total++; if (stb !== 8'h01) $display("FAIL lock_stb_ff got %b exp 00000001", stb); else pass++;
        send_byte(8'hEE, stb);
        total++; if (if0.data_out !== 8'hEE) $display("FAIL lock_data_ee got %h exp ee", if0.data_out); else pass++;
        total++; if (stb !== 8'h01) $display("FAIL lock_stb_ee got %b exp 00000001", stb); else pass++;
    endtask
    task automatic test_bit_slide();
        logic [7:0] stb;
        apply_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'hBC, stb);
        total++; if (if0.active !== 1'b1) $display("FAIL slide_active got %b exp 1", if0.active); else pass++;
        send_byte(8'h44, stb);
        total++; if (if0.data_out !== 8'h44) $display("FAIL slide_data got %h exp 44", if0.data_out); else pass++;
        total++; if (if0.valid_out !== 1'b1) $display("FAIL slide_valid got %b exp 1", if0.valid_out); else pass++;
    endtask
    task automatic test_false_lock();
        logic [7:0] stb;
        apply_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC, stb);
        send_byte(8'h11, stb);
        total++; if (if0.active !== 1'b0) $display("FAIL false_active got %b exp 0", if0.active); else pass++;
        total++; if (if0.valid_out !== 1'b0) $display("FAIL false_valid got %b exp 0", if0.valid_out); else pass++;
        send_byte(8'hBC, stb);
        total++; if (if0.active !== 1'b0) $display("FAIL false_recount_active got %b exp 0", if0.active); else pass++;
        send_byte(8'hBC, stb);
        send_byte(8'hBC, stb);
        total++; if (if0.active !== 1'b0) $display("FAIL false_3rd_active got %b exp 0", if0.active); else pass++;
        send_byte(8'hBC, stb);
        total++; if (if0.active !== 1'b1) $display("FAIL false_relock_active got %b exp 1", if0.active); else pass++;
    endtask
    task automatic test_idle_hold();
        logic [7:0] stb;
        send_byte(8'hFF, stb);
        total++; if (if0.valid_out !== 1'b1) $display("FAIL idle_valid_ff got %b exp 1", if0.valid_out); else pass++;
        total++; if (if0.data_out !== 8'hFF) $display("FAIL idle_data_ff got %h exp ff", if0.data_out); else pass++;
        send_byte(8'hBC, stb);
        total++; if (if0.valid_out !== 1'b0) $display("FAIL idle_valid_bc got %b exp 0", if0.valid_out); else pass++;
        total++; if (if0.data_out !== 8'hFF) $display("FAIL idle_data_held got %h exp ff", if0.data_out); else pass++;
        total++; if (stb !== 8'h01) $display("FAIL idle_stb_bc got %b exp 00000001", stb); else pass++;
        send_byte(8'h4E, stb);
        total++; if (if0.valid_out !== 1'b1) $display("FAIL idle_valid_4e got %b exp 1", if0.valid_out); else pass++;
        total++; if (if0.data_out !== 8'h4E) $display("FAIL idle_data_4e got %h exp 4e", if0.data_out); else pass++;
    endtask
    task automatic test_async_reset();
        logic [7:0] stb;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #0.5;
        reset = 1'b1;
        #0.5;
        total++; if (if0.data_out !== 8'h00) $display("FAIL async_data got %h exp 00", if0.data_out); else pass++;
        total++; if (if0.valid_out !== 1'b0) $display("FAIL async_valid got %b exp 0", if0.valid_out); else pass++;
        total++; if (if0.active !== 1'b0) $display("FAIL async_active got %b exp 0", if0.active); else pass++;
        total++; if (if0.byte_stb !== 1'b0) $display("FAIL async_stb got %b exp 0", if0.byte_stb); else pass++;
        @(posedge clk_8f);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) send_byte(8'hBC, stb);
        total++; if (if0.active !== 1'b0) $display("FAIL async_relock3 got %b exp 0", if0.active); else pass++;
        send_byte(8'hBC, stb);
        total++; if (if0.active !== 1'b1) $display("FAIL async_relock4 got %b exp 1", if0.active); else pass++;
        send_byte(8'h5A, stb);
        total++; if (if0.data_out !== 8'h5A) $display("FAIL async_data_5a got %h exp 5a", if0.data_out); else pass++;
    endtask
    task automatic test_count_one();
        logic [7:0] stb;
        apply_reset();
        send_byte(8'hBC, stb);
        total++; if (if1.active !== 1'b1) $display("FAIL one_active got %b exp 1", if1.active); else pass++;
        total++; if (if1.valid_out !== 1'b0) $display("FAIL one_entry_valid got %b exp 0", if1.valid_out); else pass++;
        total++; if (if0.active !== 1'b0) $display("FAIL one_ref_active got %b exp 0", if0.active); else pass++;
        send_byte(8'h55, stb);
        total++; if (if1.data_out !== 8'h55) $display("FAIL one_data got %h exp 55", if1.data_out); else pass++;
        total++; if (if1.valid_out !== 1'b1) $display("FAIL one_valid got %b exp 1", if1.valid_out); else pass++;
    endtask
    initial begin
        test_reset();
        test_lock_data();
        test_bit_slide();
        test_false_lock();
        test_idle_hold();
        test_async_reset();
        test_count_one();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
